// File: rtl/nes_pkg.sv
// Shared NES bus definitions: OAM DMA state encoding and the register
// addresses the DMA engine uses as its defaults.
package nes_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

    localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
    localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine between the CPU and the system bus: passes CPU cycles through
// when idle, and on a write to the trigger address copies one page into OAMDATA.
module oam_dma
    import nes_pkg::*;
#(
    parameter logic [15:0] TRIGGER_ADDR  = ADDR_OAMDMA,
    parameter logic [15:0] OAM_DATA_ADDR = ADDR_OAMDATA,
    parameter int          XFER_LEN      = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_d_out,
    input  logic        cpu_we,
    input  logic [7:0]  bus_d_in,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_d_out,
    output logic        bus_we,
    output logic        cpu_rdy,
    output logic        dma_active
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_t state;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] data_buf;
    logic       parity;

    // cpu_rdy and dma_active are registered alongside every state change so
    // they always agree with the state the bus mux is decoding this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            page       <= 8'h00;
            idx        <= 8'h00;
            data_buf   <= 8'h00;
            parity     <= 1'b0;
            cpu_rdy    <= 1'b1;
            dma_active <= 1'b0;
        end else begin
            parity <= ~parity;
            case (state)
                IDLE: begin
                    if (cpu_we && cpu_addr == TRIGGER_ADDR) begin
                        page       <= cpu_d_out;
                        idx        <= 8'h00;
                        state      <= HALT;
                        cpu_rdy    <= 1'b0;
                        dma_active <= 1'b1;
                    end
                end
                HALT: begin
                    state <= parity ? ALIGN : READ;
                end
                ALIGN: begin
                    state <= READ;
                end
                READ: begin
                    data_buf <= bus_d_in;
                    state    <= WRITE;
                end
                WRITE: begin
                    if (idx == LAST_IDX) begin
                        idx        <= 8'h00;
                        state      <= IDLE;
                        cpu_rdy    <= 1'b1;
                        dma_active <= 1'b0;
                    end else begin
                        idx   <= idx + 8'h01;
                        state <= READ;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cpu_rdy    <= 1'b1;
                    dma_active <= 1'b0;
                end
            endcase
        end
    end

    // While the CPU is halted it keeps presenting its address; the bus sees it
    // as a harmless non-write cycle until the copy loop takes over.
    always_comb begin
        bus_addr  = cpu_addr;
        bus_d_out = cpu_d_out;
        bus_we    = 1'b0;
        case (state)
            IDLE: begin
                bus_we = cpu_we;
            end
            HALT, ALIGN: begin
                bus_we = 1'b0;
            end
            READ: begin
                bus_addr  = {page, idx};
                bus_d_out = data_buf;
            end
            WRITE: begin
                bus_addr  = OAM_DATA_ADDR;
                bus_d_out = data_buf;
                bus_we    = 1'b1;
            end
            default: begin
                bus_we = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Randomized scoreboard bench for oam_dma: a byte-array memory model feeds the
// bus, and each expected stalled bus cycle is queued and checked by a monitor.
module tb_oam_dma;
    import nes_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_d_out;
    logic        cpu_we;
    logic [7:0]  bus_d_in;
    logic [15:0] bus_addr;
    logic [7:0]  bus_d_out;
    logic        bus_we;
    logic        cpu_rdy;
    logic        dma_active;

    oam_dma dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_d_out  (cpu_d_out),
        .cpu_we     (cpu_we),
        .bus_d_in   (bus_d_in),
        .bus_addr   (bus_addr),
        .bus_d_out  (bus_d_out),
        .bus_we     (bus_we),
        .cpu_rdy    (cpu_rdy),
        .dma_active (dma_active)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    logic ref_par;
    always @(posedge clk) ref_par <= rst ? 1'b0 : ~ref_par;

    logic [7:0] mem [0:65535];
    assign bus_d_in = mem[bus_addr];

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [24:0] exp_q[$];   // {we, addr, data}; data ignored for reads
    int len_q[$];
    int wr_cnt = 0;
    int stall_len = 0;
    logic [24:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall_len = 0;
        end else begin
            chk("cpu_rdy_vs_model", cpu_rdy, exp_q.size() == 0);
            chk("dma_active_vs_model", dma_active, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("bus_cycle_we_addr", {bus_we, bus_addr}, mon_e[24:8]);
                if (mon_e[24]) chk("oam_write_data", bus_d_out, mon_e[7:0]);
            end
            if (!cpu_rdy && bus_we && bus_addr == ADDR_OAMDATA) wr_cnt++;
            if (!cpu_rdy) begin
                stall_len++;
            end else if (stall_len > 0) begin
                if (len_q.size() == 0) chk("unexpected_stall_len", stall_len, 0);
                else chk("stall_len", stall_len, len_q.pop_front());
                stall_len = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected bus behaviour of one transfer, straight from the transfer rules.
    task automatic push_transfer(input logic [7:0] p, input bit par);
        exp_q.push_back({1'b0, cpu_addr, 8'h00});
        if (par) exp_q.push_back({1'b0, cpu_addr, 8'h00});
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back({1'b0, p, 8'(i), 8'h00});
            exp_q.push_back({1'b1, ADDR_OAMDATA, mem[{p, 8'(i)}]});
        end
        len_q.push_back(513 + int'(par));
    endtask

    task automatic trigger(input logic [7:0] p, input bit want_par);
        while (ref_par == want_par) tick();
        cpu_we    = 1'b1;
        cpu_addr  = ADDR_OAMDMA;
        cpu_d_out = p;
        @(negedge clk);
        chk("trigger_passthrough", {bus_we, bus_addr, bus_d_out}, {1'b1, ADDR_OAMDMA, p});
        tick();
        cpu_we = 1'b0;
        push_transfer(p, want_par);
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!cpu_rdy && k < 700) begin
            tick();
            k++;
        end
        if (!cpu_rdy) chk({name, "_timeout"}, 1'b0, 1'b1);
        tick();
        chk({name, "_queue_drained"}, exp_q.size(), 0);
        chk({name, "_len_drained"}, len_q.size(), 0);
    endtask

    task automatic pass_cycle(input logic [15:0] a, input logic [7:0] d, input logic we);
        cpu_addr  = a;
        cpu_d_out = d;
        cpu_we    = we;
        @(negedge clk);
        chk("pass_addr", bus_addr, a);
        chk("pass_data", bus_d_out, d);
        chk("pass_we", bus_we, we);
        tick();
        cpu_we = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        cpu_addr  = 16'h1234;
        cpu_d_out = 8'h00;
        cpu_we    = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
        tick();
        tick();
        chk("reset_cpu_rdy", cpu_rdy, 1'b1);
        chk("reset_dma_active", dma_active, 1'b0);
        chk("reset_bus_addr", bus_addr, 16'h1234);
        chk("reset_bus_we", bus_we, 1'b0);
        rst = 1'b0;
        tick();

        // passthrough, including a read of the trigger address
        pass_cycle(16'h0010, 8'h00, 1'b0);
        pass_cycle(16'h0200, 8'h55, 1'b1);
        pass_cycle(ADDR_OAMDMA, 8'h09, 1'b0);
        tick();
        chk("read_4014_no_stall", cpu_rdy, 1'b1);
        for (int n = 0; n < 20; n++) begin
            logic [15:0] a;
            a = 16'($urandom);
            if (a == ADDR_OAMDMA) a = 16'h4015;
            pass_cycle(a, 8'($urandom), 1'($urandom_range(0, 1)));
        end

        trigger(8'h02, 1'b0);
        wait_done("even");
        trigger(8'h02, 1'b1);
        wait_done("odd");
        trigger(8'hFF, 1'($urandom_range(0, 1)));
        wait_done("page_ff");

        // reset after the 100th OAMDATA write
        wr_cnt = 0;
        trigger(8'h05, 1'($urandom_range(0, 1)));
        for (int k = 0; k < 400 && wr_cnt < 100; k++) tick();
        chk("mid_reset_reached_100", wr_cnt, 100);
        rst = 1'b1;
        exp_q.delete();
        len_q.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("after_reset_cpu_rdy", cpu_rdy, 1'b1);
        chk("after_reset_dma_active", dma_active, 1'b0);
        chk("after_reset_bus_we", bus_we, 1'b0);
        wr_cnt = 0;
        for (int k = 0; k < 6; k++) tick();
        chk("no_writes_after_abort", wr_cnt, 0);
        trigger(8'h03, 1'($urandom_range(0, 1)));
        wait_done("after_abort");

        // retrigger attempts while the copy is running
        trigger(8'h04, 1'b0);
        for (int k = 0; k < 30; k++) tick();
        cpu_we    = 1'b1;
        cpu_d_out = 8'h07;
        for (int k = 0; k < 400; k++) tick();
        cpu_we = 1'b0;
        wait_done("retrigger");

        // reset wins over a simultaneous trigger
        rst       = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = ADDR_OAMDMA;
        cpu_d_out = 8'h06;
        tick();
        rst    = 1'b0;
        cpu_we = 1'b0;
        chk("rst_beats_trigger_rdy", cpu_rdy, 1'b1);
        tick();
        chk("rst_beats_trigger_active", dma_active, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
